// File: rtl/game_round_timer_pkg.sv
// Shared definitions for the game round timer: state encoding and default
// round length / round count.
package game_round_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_ZERO  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [9:0] DEF_ROUND_SECS = 10'd59;
  localparam logic [3:0] DEF_MAX_ROUNDS = 4'd8;

endpackage

// File: rtl/game_round_timer_bin2bcd10.sv
// Combinational 10-bit binary to three BCD digits (shift-add-3) for the
// display mux; inputs above 999 are never presented.
module bin2bcd10 (
  input  logic [9:0] bin,
  output logic [3:0] hund,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  function automatic logic [11:0] to_bcd(input logic [9:0] b);
    logic [11:0] acc;
    acc = 12'd0;
    for (int i = 9; i >= 0; i--) begin
      acc[3:0]  = (acc[3:0]  >= 4'd5) ? acc[3:0]  + 4'd3 : acc[3:0];
      acc[7:4]  = (acc[7:4]  >= 4'd5) ? acc[7:4]  + 4'd3 : acc[7:4];
      acc[11:8] = (acc[11:8] >= 4'd5) ? acc[11:8] + 4'd3 : acc[11:8];
      acc = {acc[10:0], b[i]};
    end
    return acc;
  endfunction

  assign {hund, tens, ones} = to_bcd(bin);

endmodule

// File: rtl/game_round_timer.sv
// Per-round countdown timer: counts each round down from ROUND_SECS to a single
// zero tick, repeats for MAX_ROUNDS rounds, then parks in DONE.
module game_round_timer
  import game_round_timer_pkg::*;
#(
  parameter logic [9:0] ROUND_SECS = DEF_ROUND_SECS,
  parameter logic [3:0] MAX_ROUNDS = DEF_MAX_ROUNDS
) (
  input  logic       clk_1H,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  output logic [9:0] seg_out,
  output logic       endf,
  output logic [3:0] round,
  output logic [3:0] bcd_hund,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       busy
);

  // A zero round length would jump straight past the countdown, so clamp it to 1.
  localparam logic [9:0] LOAD_SECS  = (ROUND_SECS == 10'd0) ? 10'd1 : ROUND_SECS;
  localparam logic [3:0] LAST_ROUND = (MAX_ROUNDS == 4'd0) ? 4'd0 : MAX_ROUNDS - 4'd1;

  state_t     state_r, state_s;
  logic [9:0] seg_r, seg_s;
  logic [3:0] round_r, round_s;
  logic       endf_r, busy_r;

  // State, countdown and round registers; endf/busy are registered from next state.
  always_ff @(posedge clk_1H or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      seg_r   <= 10'd0;
      round_r <= 4'd0;
      endf_r  <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      seg_r   <= seg_s;
      round_r <= round_s;
      endf_r  <= (state_s == ST_IDLE) || (state_s == ST_DONE);
      busy_r  <= (state_s == ST_RUN) || (state_s == ST_PAUSE) || (state_s == ST_ZERO);
    end
  end

  // Next-state and counter update; abort outranks start, start outranks pause.
  always_comb begin
    state_s = state_r;
    seg_s   = seg_r;
    round_s = round_r;
    if (abort) begin
      state_s = ST_IDLE;
      seg_s   = 10'd0;
      round_s = 4'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_s = ST_RUN;
            seg_s   = LOAD_SECS;
            round_s = 4'd0;
          end else begin
            state_s = state_r;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_s = ST_PAUSE;
          end else if (seg_r > 10'd1) begin
            seg_s = seg_r - 10'd1;
          end else begin
            // Landing on zero goes through ZERO so exactly one zero tick is seen.
            seg_s   = 10'd0;
            state_s = ST_ZERO;
          end
        end
        ST_PAUSE: begin
          if (pause) begin
            state_s = ST_PAUSE;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_ZERO: begin
          if (round_r < LAST_ROUND) begin
            state_s = ST_RUN;
            seg_s   = LOAD_SECS;
            round_s = round_r + 4'd1;
          end else begin
            state_s = ST_DONE;
            seg_s   = 10'd0;
          end
        end
        default: begin
          state_s = ST_IDLE;
          seg_s   = 10'd0;
          round_s = 4'd0;
        end
      endcase
    end
  end

  bin2bcd10 u_bcd (
    .bin  (seg_r),
    .hund (bcd_hund),
    .tens (bcd_tens),
    .ones (bcd_ones)
  );

  assign seg_out = seg_r;
  assign round   = round_r;
  assign endf    = endf_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_game_round_timer.sv
// Directed bench for game_round_timer: a small instance (3 s, 2 rounds) for
// sequencing, pause, abort and reset, and a default instance for a full game.
module tb_game_round_timer;

  logic       clk_1H = 1'b0;
  logic       reset, start, pause, abort;
  logic [9:0] seg_out;
  logic       endf, busy;
  logic [3:0] round, bcd_hund, bcd_tens, bcd_ones;

  logic       reset_b, start_b, pause_b, abort_b;
  logic [9:0] seg_b;
  logic       endf_b, busy_b;
  logic [3:0] round_b, hund_b, tens_b, ones_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_1H = ~clk_1H;

  game_round_timer #(.ROUND_SECS(10'd3), .MAX_ROUNDS(4'd2)) dut (
    .clk_1H(clk_1H), .reset(reset), .start(start), .pause(pause), .abort(abort),
    .seg_out(seg_out), .endf(endf), .round(round),
    .bcd_hund(bcd_hund), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .busy(busy)
  );

  game_round_timer dut_def (
    .clk_1H(clk_1H), .reset(reset_b), .start(start_b), .pause(pause_b), .abort(abort_b),
    .seg_out(seg_b), .endf(endf_b), .round(round_b),
    .bcd_hund(hund_b), .bcd_tens(tens_b), .bcd_ones(ones_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [9:0] s, input logic [3:0] r,
                       input logic e, input logic b);
    chk({tag, ".seg"}, seg_out, s);
    chk({tag, ".round"}, round, r);
    chk({tag, ".endf"}, endf, e);
    chk({tag, ".busy"}, busy, b);
  endtask

  task automatic tick;
    @(posedge clk_1H);
    #1;
  endtask

  initial begin
    int zeros;
    int ticks;
    logic done;

    reset = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
    reset_b = 1'b1; start_b = 1'b0; pause_b = 1'b0; abort_b = 1'b0;
    #2;
    chk_a("reset", 10'd0, 4'd0, 1'b1, 1'b0);
    chk("reset.bcd", {bcd_hund, bcd_tens, bcd_ones}, 12'h000);
    reset = 1'b0; reset_b = 1'b0;

    // Full two-round game from a single start pulse.
    start = 1'b1;
    tick; start = 1'b0;
    chk_a("g.r0s3", 10'd3, 4'd0, 1'b0, 1'b1);
    chk("g.bcd3", {bcd_hund, bcd_tens, bcd_ones}, 12'h003);
    tick; chk_a("g.r0s2", 10'd2, 4'd0, 1'b0, 1'b1);
    tick; chk_a("g.r0s1", 10'd1, 4'd0, 1'b0, 1'b1);
    tick; chk_a("g.r0z", 10'd0, 4'd0, 1'b0, 1'b1);
    tick; chk_a("g.r1s3", 10'd3, 4'd1, 1'b0, 1'b1);
    tick; chk_a("g.r1s2", 10'd2, 4'd1, 1'b0, 1'b1);
    tick; chk_a("g.r1s1", 10'd1, 4'd1, 1'b0, 1'b1);
    tick; chk_a("g.r1z", 10'd0, 4'd1, 1'b0, 1'b1);
    tick; chk_a("g.done", 10'd0, 4'd1, 1'b1, 1'b0);
    tick; chk_a("g.hold", 10'd0, 4'd1, 1'b1, 1'b0);

    // Pause for 4 ticks at seg=2, then resume tick, then 1, 0.
    start = 1'b1;
    tick; start = 1'b0;
    chk_a("p.s3", 10'd3, 4'd0, 1'b0, 1'b1);
    tick; chk_a("p.s2", 10'd2, 4'd0, 1'b0, 1'b1);
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick; chk_a("p.held", 10'd2, 4'd0, 1'b0, 1'b1);
    end
    pause = 1'b0;
    tick; chk_a("p.resume", 10'd2, 4'd0, 1'b0, 1'b1);
    tick; chk_a("p.s1", 10'd1, 4'd0, 1'b0, 1'b1);
    tick; chk_a("p.zero", 10'd0, 4'd0, 1'b0, 1'b1);

    // Pause high across the ZERO exit is ignored: reload to 3 in round 1.
    pause = 1'b1;
    tick; chk_a("pz.reload", 10'd3, 4'd1, 1'b0, 1'b1);
    tick; chk_a("pz.paused", 10'd3, 4'd1, 1'b0, 1'b1);
    pause = 1'b0;
    tick; chk_a("pz.resume", 10'd3, 4'd1, 1'b0, 1'b1);
    tick; chk_a("pz.s2", 10'd2, 4'd1, 1'b0, 1'b1);

    // Abort at seg=2 in round 1, no zero tick follows.
    abort = 1'b1;
    tick; chk_a("ab.idle", 10'd0, 4'd0, 1'b1, 1'b0);
    abort = 1'b0;
    tick; chk_a("ab.stay", 10'd0, 4'd0, 1'b1, 1'b0);

    // Abort outranks start.
    abort = 1'b1; start = 1'b1;
    tick; chk_a("prio", 10'd0, 4'd0, 1'b1, 1'b0);
    abort = 1'b0;

    // Start held high while running is ignored.
    tick; chk_a("st.s3", 10'd3, 4'd0, 1'b0, 1'b1);
    tick; chk_a("st.ign", 10'd2, 4'd0, 1'b0, 1'b1);
    start = 1'b0;

    // Asynchronous reset between edges.
    #3; reset = 1'b1;
    #1; chk_a("ar", 10'd0, 4'd0, 1'b1, 1'b0);
    chk("ar.bcd", {bcd_hund, bcd_tens, bcd_ones}, 12'h000);
    #1; reset = 1'b0;
    start = 1'b1;
    tick; start = 1'b0;
    chk_a("ar.restart", 10'd3, 4'd0, 1'b0, 1'b1);

    // Default instance: full 8-round game of 59 s rounds.
    start_b = 1'b1;
    tick; start_b = 1'b0;
    chk("d.s59", seg_b, 10'd59);
    chk("d.bcd59", {hund_b, tens_b, ones_b}, 12'h059);
    chk("d.busy", busy_b, 1'b1);
    tick;
    chk("d.bcd58", {hund_b, tens_b, ones_b}, 12'h058);
    zeros = 0;
    ticks = 1;
    done = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (!done) begin
        tick; ticks++;
        if (seg_b == 10'd0 && !endf_b) zeros++;
        if (endf_b) done = 1'b1;
      end
    end
    chk("d.finished", done, 1'b1);
    chk("d.zeros", zeros, 8);
    chk("d.ticks", ticks, 480);
    chk("d.round", round_b, 4'd7);
    chk("d.seg", seg_b, 10'd0);
    tick;
    chk("d.zeros_hold", zeros + ((seg_b == 10'd0 && !endf_b) ? 1 : 0), 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/game_round_timer.md
GAME_ROUND_TIMER -- requirements
Module: game_round_timer

Interface
REQ-001 Parameter ROUND_SECS, default 10'd59, countdown start value per round; legal range 1..999.
REQ-002 Parameter MAX_ROUNDS, default 4'd8, rounds per game; legal range 1..15.
REQ-003 clk_1H  input  1  game tick clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  level, sampled each tick; begins a game from IDLE or DONE.
REQ-006 pause  input  1  level, sampled each tick; freezes the countdown while high.
REQ-007 abort  input  1  level, sampled each tick; returns the block to IDLE.
REQ-008 seg_out  output  10  remaining seconds of the current round, binary.
REQ-009 endf  output  1  high when no game is running, i.e. in IDLE or DONE; low otherwise.
REQ-010 round  output  4  zero-based index of the current round.
REQ-011 bcd_hund, bcd_tens, bcd_ones  output  4 each  BCD digits of seg_out for the display mux.
REQ-012 busy  output  1  high in RUN, PAUSE and ZERO.

Function
REQ-013 States: IDLE, RUN, PAUSE, ZERO, DONE; all registers update only on a clk_1H edge.
REQ-014 Input priority each tick: abort > start > pause.
REQ-015 abort high in any state: next state IDLE, seg_out=0, round=0, endf=1.
REQ-016 IDLE or DONE with start high: next state RUN, seg_out=ROUND_SECS, round=0, endf=0.
REQ-017 start high in RUN, PAUSE or ZERO: ignored.
REQ-018 RUN with pause high: next state PAUSE, seg_out held.
REQ-019 RUN with pause low and seg_out>1: seg_out decrements by 1.
REQ-020 RUN with pause low and seg_out==1: seg_out becomes 0, next state ZERO.
REQ-021 PAUSE with pause high: all outputs held; with pause low: next state RUN, and the decrement resumes on the following tick.
REQ-022 ZERO lasts exactly one tick with seg_out==0 and endf==0, so that a downstream round counter increments exactly once per round.
REQ-023 pause high in ZERO: ignored.
REQ-024 ZERO exit with round < MAX_ROUNDS-1: round increments, seg_out=ROUND_SECS, next state RUN.
REQ-025 ZERO exit with round == MAX_ROUNDS-1: next state DONE, endf=1, seg_out=0, round held.
REQ-026 DONE: holds all outputs until start or abort.
REQ-027 seg_out never wraps below 0; the decrement is 10-bit unsigned, guarded by REQ-019 and REQ-020.
REQ-028 ROUND_SECS of 0 is treated as 1.
REQ-029 BCD outputs are combinational from seg_out, with zero latency; seg_out > 999 is not reachable.
REQ-030 endf and busy are registered or decoded directly from state; neither has a combinational path from an input.

Reset
REQ-031 reset high: state=IDLE, seg_out=0, round=0, endf=1, busy=0, and BCD outputs all 0, immediately and regardless of clk_1H.
REQ-032 reset mid-round abandons the round; no ZERO tick is produced.
REQ-033 After reset deasserts, the first start is honoured on the next clk_1H edge.

Structure
REQ-034 Shared package holds the state encoding constants (3 bits) and the default ROUND_SECS and MAX_ROUNDS values.
REQ-035 One sub-module, bin2bcd10: combinational 10-bit binary to 3-digit BCD conversion (shift-add-3), instantiated once.
REQ-036 The FSM and counters are a single registered process plus one next-state combinational process.

Verification (ROUND_SECS=3, MAX_ROUNDS=2 unless stated)
REQ-037 Reset, then start pulse for 1 tick -> seg_out sequence 3,2,1,0,3,2,1,0 on successive ticks; round 0 then 1; then DONE with endf=1, seg_out=0, round=1.
REQ-038 pause high for 4 ticks while seg_out=2 -> seg_out stays 2 for the pause ticks plus 1 resume tick, then 1, 0.
REQ-039 pause high across the ZERO tick -> seg_out==0 for exactly one tick, then reload to 3, round=1.
REQ-040 abort asserted with seg_out=2 in round 1 -> next tick IDLE, endf=1, seg_out=0, round=0; no ZERO tick.
REQ-041 Async reset pulse between edges during RUN -> outputs go to reset values without a clock edge; start re-honoured afterwards.
REQ-042 Defaults ROUND_SECS=59, MAX_ROUNDS=8 with a companion counter of ZERO ticks (seg_out==0 && !endf) -> counter reaches 8 exactly once at DONE; check BCD 59 -> hund 0, tens 5, ones 9.
